// File: rtl/panel_lamp_shifter.sv
// panel_lamp_shifter: scans 36-bit light rows through an external mux onto a 74HC595-style lamp chain.
// Optional build macro PANEL_LAMP_TEST_EN adds a synchronized lamp_test input that lights every lamp.
module panel_lamp_shifter #(
  parameter int NROWS  = 16,
  parameter int ADDR_W = 4,
  parameter int CLKDIV = 4,
  parameter int GAP    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
`ifdef PANEL_LAMP_TEST_EN
  input  logic              lamp_test,
`endif
  input  logic [0:35]       lamp_data,
  output logic [ADDR_W-1:0] lamp_addr,
  output logic              sclk,
  output logic              sdata,
  output logic              slatch,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_LOAD,
    S_SHIFT,
    S_LATCH,
    S_PAUSE
  } state_t;

  state_t           state;
  logic [1:35]      rest;
  logic [5:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [0:35]      load_word;

`ifdef PANEL_LAMP_TEST_EN
  logic [1:0] test_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) test_sync <= '0;
    else        test_sync <= {test_sync[0], lamp_test};
  end

  assign load_word = test_sync[1] ? 36'o777777777777 : lamp_data;
`else
  assign load_word = lamp_data;
`endif

  // Bit 0 goes straight to sdata at load time; rest holds the bits still to come.
  // lamp_addr doubles as the row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      lamp_addr  <= '0;
      rest       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      slatch     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_FETCH_ADDR;
            lamp_addr <= '0;
            busy      <= 1'b1;
          end
        end
        S_FETCH_ADDR: state <= S_FETCH_LOAD;
        S_FETCH_LOAD: begin
          rest    <= load_word[1:35];
          sdata   <= load_word[0];
          sclk    <= 1'b0;
          bit_cnt <= '0;
          div_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt != 6'd35) begin
                bit_cnt <= bit_cnt + 6'd1;
                sdata   <= rest[1];
                rest    <= {rest[2:35], 1'b0};
              end else begin
                sdata <= 1'b0;
                if (lamp_addr < ROW_LAST) begin
                  lamp_addr <= lamp_addr + ADDR_W'(1);
                  state     <= S_FETCH_ADDR;
                end else begin
                  slatch <= 1'b1;
                  state  <= S_LATCH;
                end
              end
            end
          end
        end
        S_LATCH: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt    <= '0;
            slatch     <= 1'b0;
            gap_cnt    <= '0;
            frame_done <= (GAP_LAST == '0);
            state      <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt    <= gap_cnt + GAP_W'(1);
            frame_done <= ((gap_cnt + GAP_W'(1)) == GAP_LAST);
          end else begin
            gap_cnt    <= '0;
            frame_done <= 1'b0;
            lamp_addr  <= '0;
            if (enable) begin
              state <= S_FETCH_ADDR;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_lamp_shifter.sv
// tb_panel_lamp_shifter: directed self-checking bench for panel_lamp_shifter.
// A small instance (NROWS=2, CLKDIV=1, GAP=4) covers sequencing; a default instance covers timing.
`timescale 1ns/1ps
module tb_panel_lamp_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        enable_def = 1'b0;
`ifdef PANEL_LAMP_TEST_EN
  logic        lamp_test = 1'b0;
`endif
  logic [0:35] lamp_data = '0;
  logic [0:35] lamp_data_def = '0;
  logic [0:35] rows [2];
  logic [0:35] rows_def [16];

  logic [0:0]  lamp_addr;
  logic        sclk, sdata, slatch, busy, frame_done;
  logic [3:0]  lamp_addr_def;
  logic        sclk_def, sdata_def, slatch_def, busy_def, frame_done_def;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External light mux model: registered, so data follows the address by one cycle.
  always @(posedge clk) lamp_data <= rows[lamp_addr];
  always @(posedge clk) lamp_data_def <= rows_def[lamp_addr_def];

  panel_lamp_shifter #(.NROWS(2), .ADDR_W(1), .CLKDIV(1), .GAP(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PANEL_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .lamp_data(lamp_data), .lamp_addr(lamp_addr), .sclk(sclk), .sdata(sdata),
    .slatch(slatch), .busy(busy), .frame_done(frame_done)
  );

  panel_lamp_shifter dut_def (
    .clk(clk), .reset(reset), .enable(enable_def),
`ifdef PANEL_LAMP_TEST_EN
    .lamp_test(1'b0),
`endif
    .lamp_data(lamp_data_def), .lamp_addr(lamp_addr_def), .sclk(sclk_def), .sdata(sdata_def),
    .slatch(slatch_def), .busy(busy_def), .frame_done(frame_done_def)
  );

  // Runs the small instance from the current negedge until the next frame_done sample.
  task automatic run_frame(input int drop_at, output logic [0:71] bits, output int rises,
                           output int latch_hi, output int latch_to_done, output int overlap,
                           output int cycles, output int addr_changes, output int busy_low,
                           output int drop_addr, output bit timed_out);
    logic prev_sclk;
    logic [0:0] prev_addr;
    int last_latch;
    bits = '0; rises = 0; latch_hi = 0; latch_to_done = -1; overlap = 0; cycles = 0;
    addr_changes = 0; busy_low = 0; drop_addr = -1; timed_out = 1'b1; last_latch = -1000;
    prev_sclk = sclk;
    prev_addr = lamp_addr;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        if (rises < 72) bits[rises] = sdata;
        rises++;
        if (rises == drop_at && enable) begin
          enable = 1'b0;
          drop_addr = int'(lamp_addr);
        end
      end
      prev_sclk = sclk;
      if (lamp_addr != prev_addr) addr_changes++;
      prev_addr = lamp_addr;
      if (!busy) busy_low++;
      if (slatch) begin
        latch_hi++;
        last_latch = c;
      end
      if (sclk && slatch) overlap++;
      if (frame_done) begin
        latch_to_done = c - last_latch;
        cycles = c;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({lamp_addr, sclk, sdata, slatch, busy, frame_done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {lamp_addr, sclk, sdata, slatch, busy, frame_done});
    end
    checks++;
    if ({lamp_addr_def, sclk_def, slatch_def, busy_def} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_def: got %b expected 0000000",
               {lamp_addr_def, sclk_def, slatch_def, busy_def});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, sclk} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_without_enable: got busy,sclk=%b expected 00", {busy, sclk});
    end
  endtask

  task automatic test_single_frame;
    logic [0:71] bits, expected;
    int rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr;
    bit to;
    rows[0] = 36'o444444555555;
    rows[1] = 36'o000000000001;
    expected = {rows[0], rows[1]};
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, lamp_addr} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL start_busy: got busy,addr=%b expected 10", {busy, lamp_addr});
    end
    run_frame(-1, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL frame1_timeout: got no frame_done expected frame_done");
    end
    checks++;
    if (rises !== 72) begin
      errors++;
      $display("[TB] FAIL frame1_rises: got %0d expected 72", rises);
    end
    checks++;
    if (bits !== expected) begin
      errors++;
      $display("[TB] FAIL frame1_bits: got %o expected %o", bits, expected);
    end
    checks++;
    if (latch_hi !== 1) begin
      errors++;
      $display("[TB] FAIL frame1_latch_len: got %0d expected 1", latch_hi);
    end
    checks++;
    if (l2d !== 4) begin
      errors++;
      $display("[TB] FAIL frame1_latch_to_done: got %0d expected 4", l2d);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("[TB] FAIL frame1_sclk_slatch_overlap: got %0d expected 0", overlap);
    end
  endtask

  task automatic test_back_to_back;
    logic [0:71] bits;
    int rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr;
    int total_chg, total_low;
    bit to;
    total_chg = 0;
    total_low = 0;
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
      total_chg += achg;
      total_low += blow;
      checks++;
      if (to || cycles !== 153) begin
        errors++;
        $display("[TB] FAIL b2b_period%0d: got %0d (timeout=%0d) expected 153", f, cycles, to);
      end
    end
    checks++;
    if (total_chg !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_addr_changes: got %0d expected 4", total_chg);
    end
    checks++;
    if (total_low !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_busy_low: got %0d expected 0", total_low);
    end
  endtask

  task automatic test_disable_midframe;
    logic [0:71] bits;
    int rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, late_rises, late_busy;
    bit to;
    run_frame(40, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
    checks++;
    if (daddr !== 1) begin
      errors++;
      $display("[TB] FAIL drop_in_row1: got addr %0d expected 1", daddr);
    end
    checks++;
    if (to || rises !== 72) begin
      errors++;
      $display("[TB] FAIL drop_rises: got %0d (timeout=%0d) expected 72", rises, to);
    end
    checks++;
    if (latch_hi !== 1) begin
      errors++;
      $display("[TB] FAIL drop_latch: got %0d expected 1", latch_hi);
    end
    checks++;
    if (bits !== {rows[0], rows[1]}) begin
      errors++;
      $display("[TB] FAIL drop_bits: got %o expected %o", bits, {rows[0], rows[1]});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_busy_fall: got %b expected 0", busy);
    end
    late_rises = 0;
    late_busy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sclk) late_rises++;
      if (busy) late_busy++;
    end
    checks++;
    if (late_rises !== 0 || late_busy !== 0) begin
      errors++;
      $display("[TB] FAIL drop_quiet: got sclk_high=%0d busy_high=%0d expected 0 0", late_rises, late_busy);
    end
  endtask

  task automatic test_reset_midframe;
    logic [0:71] bits;
    int rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, seen;
    bit to;
    logic prev_sclk;
    rows[0] = 36'o123456701234;
    rows[1] = 36'o765432107654;
    enable = 1'b1;
    seen = 0;
    prev_sclk = sclk;
    for (int c = 0; c < 100 && seen < 10; c++) begin
      @(negedge clk);
      if (sclk && !prev_sclk) seen++;
      prev_sclk = sclk;
    end
    checks++;
    if (seen !== 10 || sdata !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_setup: got rises=%0d sdata=%b expected 10 1", seen, sdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({sclk, sdata, slatch, busy, frame_done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %b expected 00000", {sclk, sdata, slatch, busy, frame_done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(-1, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
    checks++;
    if (to || rises !== 72) begin
      errors++;
      $display("[TB] FAIL midreset_rises: got %0d (timeout=%0d) expected 72", rises, to);
    end
    checks++;
    if (bits !== {rows[0], rows[1]}) begin
      errors++;
      $display("[TB] FAIL midreset_bits: got %o expected %o", bits, {rows[0], rows[1]});
    end
  endtask

`ifdef PANEL_LAMP_TEST_EN
  task automatic test_lamp_test;
    logic [0:71] bits;
    int rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr;
    bit to;
    rows[0] = '0;
    rows[1] = '0;
    lamp_test = 1'b1;
    run_frame(-1, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
    checks++;
    if (to || rises !== 72 || bits !== {72{1'b1}}) begin
      errors++;
      $display("[TB] FAIL lamp_test_on: got %o rises=%0d expected all ones", bits, rises);
    end
    lamp_test = 1'b0;
    run_frame(-1, bits, rises, latch_hi, l2d, overlap, cycles, achg, blow, daddr, to);
    checks++;
    if (to || rises !== 72 || bits !== 72'b0) begin
      errors++;
      $display("[TB] FAIL lamp_test_off: got %o rises=%0d expected all zeros", bits, rises);
    end
  endtask
`endif

  task automatic test_defaults;
    int period, hi_runs, bad_hi, bad_lo, hi_len, lo_len, latch_len, latch_runs, overlap;
    bit found;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) rows_def[i] = 36'(i * 12345 + 7);
    @(negedge clk);
    checks++;
    if (busy_def !== 1'b0) begin
      errors++;
      $display("[TB] FAIL def_idle: got busy=%b expected 0", busy_def);
    end
    enable_def = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 6000 && !found; c++) begin
      @(negedge clk);
      if (frame_done_def) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL def_first_frame: got no frame_done expected frame_done");
    end
    period = 0; hi_runs = 0; bad_hi = 0; bad_lo = 0; hi_len = 0; lo_len = 0;
    latch_len = 0; latch_runs = 0; overlap = 0; found = 1'b0;
    for (int c = 1; c <= 6000 && !found; c++) begin
      @(negedge clk);
      if (sclk_def) begin
        if (lo_len != 0 && lo_len != 4 && lo_len != 6) bad_lo++;
        lo_len = 0;
        hi_len++;
      end else begin
        if (hi_len != 0) begin
          hi_runs++;
          if (hi_len != 4) bad_hi++;
        end
        hi_len = 0;
        lo_len++;
      end
      if (slatch_def) latch_len++;
      else if (latch_len != 0 && latch_runs == 0) latch_runs = latch_len;
      if (sclk_def && slatch_def) overlap++;
      if (frame_done_def) begin
        period = c;
        found = 1'b1;
      end
    end
    checks++;
    if (period !== 4744) begin
      errors++;
      $display("[TB] FAIL def_period: got %0d expected 4744", period);
    end
    checks++;
    if (hi_runs !== 576 || bad_hi !== 0) begin
      errors++;
      $display("[TB] FAIL def_sclk_high: got runs=%0d bad=%0d expected 576 0", hi_runs, bad_hi);
    end
    checks++;
    if (bad_lo !== 0) begin
      errors++;
      $display("[TB] FAIL def_sclk_low: got bad=%0d expected 0", bad_lo);
    end
    checks++;
    if (latch_runs !== 4) begin
      errors++;
      $display("[TB] FAIL def_latch_len: got %0d expected 4", latch_runs);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("[TB] FAIL def_overlap: got %0d expected 0", overlap);
    end
    enable_def = 1'b0;
  endtask

  initial begin
    rows[0] = '0;
    rows[1] = '0;
    for (int i = 0; i < 16; i++) rows_def[i] = '0;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_disable_midframe;
    test_reset_midframe;
`ifdef PANEL_LAMP_TEST_EN
    test_lamp_test;
`endif
    test_defaults;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
